// File: rtl/mmult_pkg.sv
// Shared types and constants for the sequential 3x3 matrix multiplier.
package mmult_pkg;

    localparam int DIM        = 3;
    localparam int ENTRIES    = 9;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 17;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mmult_seq_if.sv
// Enable/valid matrix-multiply bus between a host and the multiplier.
// Matrices are row-major, entry 0 in the most significant (lowest-index) slice.
interface mmult_seq_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17
);
    logic                   enable;
    logic [0:9*DATA_W-1]    A_mat;
    logic [0:9*DATA_W-1]    B_mat;
    logic                   valid;
    logic [0:9*ACC_W-1]     C_mat;

    modport master (output enable, A_mat, B_mat, input valid, C_mat);
    modport slave  (input enable, A_mat, B_mat, output valid, C_mat);
endinterface

// File: rtl/mmult_dot3.sv
// Combinational 3-term unsigned dot product with reduction to ACC_W bits.
// Build option MMULT_SAT_EN: saturate sums >= 2^ACC_W to all-ones instead
// of keeping the low ACC_W bits.
module mmult_dot3 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17
) (
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    output logic [ACC_W-1:0]  dot
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 2;
    // Wide enough to hold both the raw sum and the ACC_W limit.
    localparam int EXT_W  = (SUM_W > ACC_W) ? SUM_W : ACC_W;

    logic [PROD_W-1:0] p0, p1, p2;
    logic [SUM_W-1:0]  sum;
    logic [EXT_W-1:0]  sum_ext;

    // Full-precision products and their sum; no bits lost before reduction.
    always_comb begin
        p0      = PROD_W'(a0) * PROD_W'(b0);
        p1      = PROD_W'(a1) * PROD_W'(b1);
        p2      = PROD_W'(a2) * PROD_W'(b2);
        sum     = SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2);
        sum_ext = EXT_W'(sum);
    end

    // Reduce the sum to the result width: clamp or wrap depending on build.
    always_comb begin
`ifdef MMULT_SAT_EN
        if (sum_ext > EXT_W'({ACC_W{1'b1}}))
            dot = {ACC_W{1'b1}};
        else
            dot = sum_ext[ACC_W-1:0];
`else
        dot = sum_ext[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/mmult_seq.sv
// Sequential 3x3 unsigned matrix multiplier, C = A x B, one C entry per cycle.
// Operands are latched when a computation starts; enable low during CALC
// aborts, keeping already-written entries. MMULT_SAT_EN selects saturating
// reduction inside mmult_dot3.
module mmult_seq
    import mmult_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    mmult_seq_if.slave  bus
);
    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 valid_reg, valid_next;
    logic                 latch_en, wr_en;

    logic [DATA_W-1:0]    a_in  [ENTRIES];
    logic [DATA_W-1:0]    b_in  [ENTRIES];
    logic [DATA_W-1:0]    a_reg [ENTRIES];
    logic [DATA_W-1:0]    b_reg [ENTRIES];
    logic [ACC_W-1:0]     c_reg [ENTRIES];

    logic [IDX_W-1:0]     row_base, col_sel;
    logic [DATA_W-1:0]    a_op  [DIM];
    logic [DATA_W-1:0]    b_op  [DIM];
    logic [ACC_W-1:0]     dot;

    // Unpack the flat bus matrices and pack the result registers back out.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_pack
        assign a_in[gi] = bus.A_mat[gi*DATA_W +: DATA_W];
        assign b_in[gi] = bus.B_mat[gi*DATA_W +: DATA_W];
        assign bus.C_mat[gi*ACC_W +: ACC_W] = c_reg[gi];
    end

    assign bus.valid = valid_reg;

    // Map the linear entry index onto row start in A and column in B.
    always_comb begin
        row_base = (idx_reg / IDX_W'(DIM)) * IDX_W'(DIM);
        col_sel  = idx_reg % IDX_W'(DIM);
    end

    // Pick row r of latched A and column c of latched B.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_opsel
        assign a_op[gi] = a_reg[row_base + IDX_W'(gi)];
        assign b_op[gi] = b_reg[IDX_W'(gi * DIM) + col_sel];
    end

    mmult_dot3 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_dot3 (
        .a0 (a_op[0]), .a1 (a_op[1]), .a2 (a_op[2]),
        .b0 (b_op[0]), .b1 (b_op[1]), .b2 (b_op[2]),
        .dot(dot)
    );

    // Next-state and control decode; valid is registered from valid_next.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        valid_next = 1'b0;
        latch_en   = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.enable) begin
                    latch_en   = 1'b1;
                    idx_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end else begin
                    wr_en = 1'b1;
                    if (idx_reg == IDX_W'(ENTRIES - 1)) begin
                        state_next = DONE;
                        valid_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.enable)
                    valid_next = 1'b1;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, entry index and valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
        end
    end

    // Operand copies, captured once per computation so bus changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else if (latch_en) begin
            for (int i = 0; i < ENTRIES; i++) begin
                a_reg[i] <= a_in[i];
                b_reg[i] <= b_in[i];
            end
        end
    end

    // Result entries, written one per CALC cycle and held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++)
                c_reg[i] <= '0;
        end else if (wr_en) begin
            c_reg[idx_reg] <= dot;
        end
    end
endmodule
